prog_loader: RTL and testbench

Byte-stream program loader that fills the CPU instruction memory in hardware, replacing the simulation-only file preload. A host or UART front end pushes a length-prefixed byte stream over a valid/ready interface. The block assembles big-endian 32-bit instruction words, writes them sequentially from address 0 into the instruction memory write port, and holds the CPU in reset until the image is complete. It sits beside `CPU` at top level and drives the instruction-memory write port and the CPU hold.

---
 rtl/prog_loader.sv | 95 +++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader: assembles big-endian 32-bit words and
// writes them from address 0 into instruction memory, holding the CPU until done.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t            state, state_n;
  logic [15:0]       len;
  logic [23:0]       asm_q;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic [15:0]       len_n;
  logic              hs, word_fire, restart;

  // Status and flow control decode straight from the state register.
  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign cpu_hold = (state != S_DONE);

  always_comb begin
    state_n   = state;
    hs        = in_valid && in_ready;
    word_fire = 1'b0;
    restart   = 1'b0;
    len_n     = {len[15:8], in_data};
    case (state)
      S_LEN_HI: if (hs) state_n = S_LEN_LO;
      S_LEN_LO: if (hs) begin
        if (len_n == 16'd0)             state_n = S_DONE;
        else if (17'(len_n) > CAP)      state_n = S_ERR;
        else                            state_n = S_DATA;
      end
      S_DATA: begin
        word_fire = hs && (byte_cnt == 2'd3);
        // word_cnt has already advanced past the word being written this cycle
        if (mem_we && (17'(word_cnt) == 17'(len))) state_n = S_DONE;
      end
      S_DONE, S_ERR: if (start) begin
        restart = 1'b1;
        state_n = S_LEN_HI;
      end
      default: state_n = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LEN_HI;
      len       <= '0;
      asm_q     <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_n;
      mem_we <= word_fire;
      if (hs && state == S_LEN_HI) len[15:8] <= in_data;
      if (hs && state == S_LEN_LO) len[7:0]  <= in_data;
      if (hs && state == S_DATA) begin
        asm_q    <= {asm_q[15:0], in_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (word_fire) begin
        mem_addr  <= word_cnt[ADDR_W-1:0];
        mem_wdata <= {asm_q, in_data};
        word_cnt  <= word_cnt + 1'b1;
      end
      if (restart) begin
        byte_cnt <= '0;
        word_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-width instance and an ADDR_W=4
// instance share stimulus; writes are logged and compared to hand-derived values.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] in_data;

  logic       rdy10, we10, hold10, done10, err10;
  logic [9:0] addr10;
  logic [31:0] wd10;
  logic       rdy4, we4, hold4, done4, err4;
  logic [3:0] addr4;
  logic [31:0] wd4;

  prog_loader dut10 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy10), .mem_we(we10), .mem_addr(addr10), .mem_wdata(wd10),
    .cpu_hold(hold10), .done(done10), .err(err10));

  prog_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy4), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wd4),
    .cpu_hold(hold4), .done(done4), .err(err4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [9:0] a; logic [31:0] d; } wr_t;
  wr_t wq10[$];
  wr_t wq4[$];

  always @(negedge clk) begin
    if (we10) wq10.push_back('{addr10, wd10});
    if (we4)  wq4.push_back('{10'(addr4), wd4});
  end

  typedef struct {
    logic        vld;
    logic [7:0]  d;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        dn;
    logic        hold;
    logic        rdy;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wq10.delete();
    wq4.delete();
  endtask

  // Offer one byte after 'gap' idle cycles; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!rdy10 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) chk("send_timeout", 32'(rdy10), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle_step();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"},   32'(we10),   32'd0);
    chk({tag, "_addr"}, 32'(addr10), 32'd0);
    chk({tag, "_wd"},   wd10,        32'd0);
    chk({tag, "_done"}, 32'(done10), 32'd0);
    chk({tag, "_err"},  32'(err10),  32'd0);
    chk({tag, "_hold"}, 32'(hold10), 32'd1);
    chk({tag, "_rdy"},  32'(rdy10),  32'd1);
  endtask

  vec_t tbl[12];
  logic [7:0] stream2[10];

  initial begin
    stream2 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    // {valid, data} -> outputs in the cycle after that edge
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 8'h12, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 8'h34, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 8'h56, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 8'h78, 1'b1, 10'd0, 32'h12345678, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 8'h9A, 1'b0, 10'd0, 32'h12345678, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 8'hBC, 1'b0, 10'd0, 32'h12345678, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 8'hDE, 1'b0, 10'd0, 32'h12345678, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 8'hF0, 1'b1, 10'd1, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 10'd1, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h55, 1'b0, 10'd1, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b0};

    // Reset state and back-to-back two-word image
    do_reset();
    chk_reset_state("rst");
    chk("rst4_hold", 32'(hold4), 32'd1);
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("t1_we[%0d]", i),   32'(we10),   32'(tbl[i].we));
      chk($sformatf("t1_addr[%0d]", i), 32'(addr10), 32'(tbl[i].addr));
      chk($sformatf("t1_wd[%0d]", i),   wd10,        tbl[i].wd);
      chk($sformatf("t1_done[%0d]", i), 32'(done10), 32'(tbl[i].dn));
      chk($sformatf("t1_hold[%0d]", i), 32'(hold10), 32'(tbl[i].hold));
      chk($sformatf("t1_rdy[%0d]", i),  32'(rdy10),  32'(tbl[i].rdy));
    end
    chk("t1_nwr", wq10.size(), 32'd2);

    // Same image with random valid gaps
    do_reset();
    for (int i = 0; i < 10; i++) send(stream2[i], int'($urandom_range(0, 3)));
    idle_step();
    chk("t2_done", 32'(done10), 32'd1);
    chk("t2_nwr", wq10.size(), 32'd2);
    if (wq10.size() == 2) begin
      chk("t2_a0", 32'(wq10[0].a), 32'd0);
      chk("t2_d0", wq10[0].d, 32'h12345678);
      chk("t2_a1", 32'(wq10[1].a), 32'd1);
      chk("t2_d1", wq10[1].d, 32'h9ABCDEF0);
    end

    // Zero-length image
    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    chk("t3_done", 32'(done10), 32'd1);
    chk("t3_hold", 32'(hold10), 32'd0);
    chk("t3_rdy",  32'(rdy10),  32'd0);
    repeat (3) idle_step();
    chk("t3_nwr", wq10.size(), 32'd0);

    // Oversize length on the 16-word instance
    do_reset();
    send(8'h00, 0);
    send(8'h11, 0);
    in_valid = 1'b0;
    chk("t4_err",   32'(err4),  32'd1);
    chk("t4_hold",  32'(hold4), 32'd1);
    chk("t4_rdy",   32'(rdy4),  32'd0);
    chk("t4_err10", 32'(err10), 32'd0);
    for (int i = 0; i < 4; i++) send(8'(i), 0);
    idle_step();
    chk("t4_nwr4", wq4.size(), 32'd0);
    chk("t4_err_hold", 32'(err4), 32'd1);

    // Exactly-full image on the 16-word instance
    do_reset();
    send(8'h00, 0);
    send(8'h10, 0);
    for (int i = 0; i < 64; i++) send(8'(i), 0);
    chk("t5_we_last", 32'(we4), 32'd1);
    chk("t5_done_early", 32'(done4), 32'd0);
    idle_step();
    chk("t5_done", 32'(done4), 32'd1);
    chk("t5_hold", 32'(hold4), 32'd0);
    chk("t5_nwr", wq4.size(), 32'd16);
    if (wq4.size() == 16) begin
      chk("t5_alast", 32'(wq4[15].a), 32'd15);
      chk("t5_dlast", wq4[15].d, 32'h3C3D3E3F);
      chk("t5_d0", wq4[0].d, 32'h00010203);
    end

    // Reset mid-load, then a fresh one-word image
    do_reset();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("t6");
    chk("t6_nwr", wq10.size(), 32'd1);
    if (wq10.size() == 1) chk("t6_d0", wq10[0].d, 32'h11223344);
    wq10.delete();
    send(8'h00, 0); send(8'h01, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    idle_step();
    chk("t6_done", 32'(done10), 32'd1);
    chk("t6_nwr2", wq10.size(), 32'd1);
    if (wq10.size() == 1) begin
      chk("t6_a", 32'(wq10[0].a), 32'd0);
      chk("t6_d", wq10[0].d, 32'hAABBCCDD);
    end

    // Restart from DONE
    wq10.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t7_done", 32'(done10), 32'd0);
    chk("t7_hold", 32'(hold10), 32'd1);
    chk("t7_rdy",  32'(rdy10),  32'd1);
    send(8'h00, 0); send(8'h01, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    idle_step();
    chk("t7_done2", 32'(done10), 32'd1);
    chk("t7_nwr", wq10.size(), 32'd1);
    if (wq10.size() == 1) begin
      chk("t7_a", 32'(wq10[0].a), 32'd0);
      chk("t7_d", wq10[0].d, 32'h01020304);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
